// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between mem_stage (master) and the memory (slave).
interface mem_stage_if;
    logic        memReq;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memWrData;
    logic        memAck;
    logic [15:0] memRdData;

    modport master (
        output memReq, memWr, memAddr, memWrData,
        input  memAck, memRdData
    );

    modport slave (
        input  memReq, memWr, memAddr, memWrData,
        output memAck, memRdData
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack wait FSM with timeout, upstream stall, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHK_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aluOut,
    input  logic [15:0] reg2Data,
    input  logic [15:0] setVal,
    input  logic [15:0] nextPc,
    input  logic        memEn,
    input  logic        memWrt,
    input  logic        regWrt,
    input  logic [2:0]  regWrtSrc,
    input  logic [2:0]  writeReg,
    input  logic        halt,
    input  logic        errIn,
    mem_stage_if.master mem,
    output logic        stall,
    output logic [15:0] memDataOut,
    output logic [15:0] aluOutOut,
    output logic [15:0] setValOut,
    output logic [15:0] nextPcOut,
    output logic        regWrtOut,
    output logic [2:0]  regWrtSrcOut,
    output logic [2:0]  writeRegOut,
    output logic        haltOut,
    output logic        errOut,
    output logic        validOut
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             req_s;
    logic             stall_s;
    logic             done_s;
    logic             abort_s;
    logic             align_fault_s;
    logic             err_s;

`ifdef MEM_ALIGN_CHK_EN
    // A misaligned access never reaches memory; it retires immediately as an error.
    assign align_fault_s = (state_r == S_IDLE) && memEn && aluOut[0];
`else
    assign align_fault_s = 1'b0;
`endif

    // State and wait-counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, request and stall decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (memEn && !align_fault_s) begin
                    req_s = 1'b1;
                    if (mem.memAck) begin
                        done_s = 1'b1;
                    end else begin
                        stall_s      = 1'b1;
                        state_next_s = S_WAIT;
                        cnt_next_s   = CNT_W'(1);
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem.memAck) begin
                    req_s        = 1'b1;
                    done_s       = 1'b1;
                    state_next_s = S_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (cnt_r < CNT_LAST) begin
                    req_s      = 1'b1;
                    stall_s    = 1'b1;
                    cnt_next_s = cnt_r + CNT_W'(1);
                end else begin
                    // Request is withdrawn in the abort cycle so memory never sees a late ack.
                    abort_s      = 1'b1;
                    state_next_s = S_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_next_s = S_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign mem.memReq    = rst & req_s;
    assign mem.memWr     = memWrt;
    assign mem.memAddr   = aluOut;
    assign mem.memWrData = reg2Data;
    assign stall         = rst & stall_s;
    assign err_s         = errIn | abort_s | align_fault_s;

    // MEM/WB pipeline register: bubble while stalled, otherwise retire the instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memDataOut   <= 16'h0000;
            aluOutOut    <= 16'h0000;
            setValOut    <= 16'h0000;
            nextPcOut    <= 16'h0000;
            regWrtOut    <= 1'b0;
            regWrtSrcOut <= 3'b000;
            writeRegOut  <= 3'b000;
            haltOut      <= 1'b0;
            errOut       <= 1'b0;
            validOut     <= 1'b0;
        end else if (stall_s) begin
            regWrtOut <= 1'b0;
            haltOut   <= 1'b0;
            errOut    <= 1'b0;
            validOut  <= 1'b0;
        end else begin
            memDataOut   <= (done_s && !memWrt) ? mem.memRdData : 16'h0000;
            aluOutOut    <= aluOut;
            setValOut    <= setVal;
            nextPcOut    <= nextPc;
            regWrtOut    <= regWrt & ~err_s;
            regWrtSrcOut <= regWrtSrc;
            writeRegOut  <= writeReg;
            haltOut      <= halt;
            errOut       <= err_s;
            validOut     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected MEM/WB results, a monitor checks them.
module tb_mem_stage;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] r2;
        logic [15:0] sv;
        logic [15:0] np;
        logic        en;
        logic        wrt;
        logic        rw;
        logic [2:0]  src;
        logic [2:0]  wr;
        logic        hl;
        logic        ei;
    } instr_t;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] alu;
        logic [15:0] sv;
        logic [15:0] np;
        logic        rw;
        logic [2:0]  src;
        logic [2:0]  wr;
        logic        hl;
        logic        er;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] aluOut, reg2Data, setVal, nextPc;
    logic        memEn, memWrt, regWrt, halt, errIn;
    logic [2:0]  regWrtSrc, writeReg;
    logic        stall;
    logic [15:0] memDataOut, aluOutOut, setValOut, nextPcOut;
    logic        regWrtOut, haltOut, errOut, validOut;
    logic [2:0]  regWrtSrcOut, writeRegOut;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    exp_t mon_exp;
    exp_t mon_act;

    mem_stage_if mif();

    mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .aluOut(aluOut), .reg2Data(reg2Data), .setVal(setVal), .nextPc(nextPc),
        .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt), .regWrtSrc(regWrtSrc),
        .writeReg(writeReg), .halt(halt), .errIn(errIn),
        .mem(mif),
        .stall(stall),
        .memDataOut(memDataOut), .aluOutOut(aluOutOut), .setValOut(setValOut),
        .nextPcOut(nextPcOut), .regWrtOut(regWrtOut), .regWrtSrcOut(regWrtSrcOut),
        .writeRegOut(writeRegOut), .haltOut(haltOut), .errOut(errOut), .validOut(validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every retired instruction must match the oldest expected result.
    always @(negedge clk) begin
        if (rst === 1'b1 && validOut === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: validOut=1 with no expected result queued");
            end else begin
                mon_exp = sb_q.pop_front();
                mon_act = '{memDataOut, aluOutOut, setValOut, nextPcOut, regWrtOut,
                            regWrtSrcOut, writeRegOut, haltOut, errOut};
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic instr_t mk_in(input logic [15:0] alu, r2, sv, np,
                                     input logic en, wrt, rw,
                                     input logic [2:0] src, wr,
                                     input logic hl, ei);
        mk_in = '{alu, r2, sv, np, en, wrt, rw, src, wr, hl, ei};
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] data, alu, sv, np,
                                    input logic rw,
                                    input logic [2:0] src, wr,
                                    input logic hl, er);
        mk_exp = '{data, alu, sv, np, rw, src, wr, hl, er};
    endfunction

    task automatic set_in(input instr_t i);
        aluOut = i.alu; reg2Data = i.r2; setVal = i.sv; nextPc = i.np;
        memEn = i.en; memWrt = i.wrt; regWrt = i.rw;
        regWrtSrc = i.src; writeReg = i.wr; halt = i.hl; errIn = i.ei;
    endtask

    // Present one instruction; memAck rises on request cycle ack_at (0 = never). Returns after the retiring edge.
    task automatic do_instr(input string nm, input instr_t i, input int ack_at,
                            input logic [15:0] rdata, input int exp_req,
                            input int exp_stall, input exp_t e);
        int   c;
        int   n_req;
        int   n_stall;
        int   n_bub;
        logic done;
        logic bus_ok;
        c = 0; n_req = 0; n_stall = 0; n_bub = 0; done = 1'b0; bus_ok = 1'b1;
        sb_q.push_back(e);
        set_in(i);
        while (!done && c < 40) begin
            c++;
            mif.memAck    = (c == ack_at);
            mif.memRdData = rdata;
            @(negedge clk);
            if (mif.memReq === 1'b1) begin
                n_req++;
                if (mif.memAddr !== i.alu || mif.memWrData !== i.r2 || mif.memWr !== i.wrt)
                    bus_ok = 1'b0;
            end
            if (stall === 1'b1) n_stall++;
            else done = 1'b1;
            @(posedge clk);
            #1;
            if (!done && validOut === 1'b0 && regWrtOut === 1'b0) n_bub++;
        end
        mif.memAck = 1'b0;
        chk({nm, "_req_cycles"}, n_req, exp_req);
        chk({nm, "_stall_cycles"}, n_stall, exp_stall);
        chk({nm, "_bubbles"}, n_bub, exp_stall);
        if (exp_req > 0) chk({nm, "_bus"}, {31'b0, bus_ok}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        mif.memAck = 1'b0;
        mif.memRdData = 16'h0000;
        set_in(mk_in(16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0));
        #2;
        chk("rst_memreq", {31'b0, mif.memReq}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_outs", {31'b0, |{memDataOut, aluOutOut, setValOut, nextPcOut, regWrtOut,
                                 regWrtSrcOut, writeRegOut, haltOut, errOut, validOut}}, 32'd0);
        set_in(mk_in(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b1;

        do_instr("passthru",
                 mk_in(16'h0007, 16'h0000, 16'h0001, 16'h0022, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 1'b1, 1'b0),
                 0, 16'h0000, 0, 0,
                 mk_exp(16'h0000, 16'h0007, 16'h0001, 16'h0022, 1'b1, 3'd2, 3'd5, 1'b1, 1'b0));
        do_instr("load0",
                 mk_in(16'h0040, 16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b1, 3'd1, 3'd3, 1'b0, 1'b0),
                 1, 16'hBEEF, 1, 0,
                 mk_exp(16'hBEEF, 16'h0040, 16'h0000, 16'h0002, 1'b1, 3'd1, 3'd3, 1'b0, 1'b0));
        do_instr("store3",
                 mk_in(16'h0100, 16'h1234, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0),
                 3, 16'hDEAD, 3, 2,
                 mk_exp(16'h0000, 16'h0100, 16'h0000, 16'h0004, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
        do_instr("load_last",
                 mk_in(16'h0200, 16'h0000, 16'h0000, 16'h0006, 1'b1, 1'b0, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0),
                 4, 16'h5A5A, 4, 3,
                 mk_exp(16'h5A5A, 16'h0200, 16'h0000, 16'h0006, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0));
        do_instr("timeout",
                 mk_in(16'h0300, 16'h0000, 16'h0000, 16'h0008, 1'b1, 1'b0, 1'b1, 3'd1, 3'd4, 1'b1, 1'b0),
                 0, 16'h7777, 3, 3,
                 mk_exp(16'h0000, 16'h0300, 16'h0000, 16'h0008, 1'b0, 3'd1, 3'd4, 1'b1, 1'b1));
        do_instr("err_in",
                 mk_in(16'h0011, 16'h0000, 16'h0003, 16'h000A, 1'b0, 1'b0, 1'b1, 3'd0, 3'd6, 1'b0, 1'b1),
                 0, 16'h0000, 0, 0,
                 mk_exp(16'h0000, 16'h0011, 16'h0003, 16'h000A, 1'b0, 3'd0, 3'd6, 1'b0, 1'b1));
        do_instr("stray_ack",
                 mk_in(16'h0050, 16'h9999, 16'h0000, 16'h000C, 1'b0, 1'b1, 1'b1, 3'd3, 3'd1, 1'b0, 1'b0),
                 1, 16'hFFFF, 0, 0,
                 mk_exp(16'h0000, 16'h0050, 16'h0000, 16'h000C, 1'b1, 3'd3, 3'd1, 1'b0, 1'b0));
`ifdef MEM_ALIGN_CHK_EN
        do_instr("align",
                 mk_in(16'h0101, 16'h0000, 16'h0000, 16'h000E, 1'b1, 1'b0, 1'b1, 3'd1, 3'd7, 1'b0, 1'b0),
                 1, 16'h1111, 0, 0,
                 mk_exp(16'h0000, 16'h0101, 16'h0000, 16'h000E, 1'b0, 3'd1, 3'd7, 1'b0, 1'b1));
`else
        do_instr("align",
                 mk_in(16'h0101, 16'h0000, 16'h0000, 16'h000E, 1'b1, 1'b0, 1'b1, 3'd1, 3'd7, 1'b0, 1'b0),
                 1, 16'h1111, 1, 0,
                 mk_exp(16'h1111, 16'h0101, 16'h0000, 16'h000E, 1'b1, 3'd1, 3'd7, 1'b0, 1'b0));
`endif

        // Reset in the middle of an outstanding access.
        set_in(mk_in(16'h0400, 16'h0000, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0));
        mif.memAck = 1'b0;
        @(negedge clk);
        chk("mid_idle_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_wait_req", {31'b0, mif.memReq}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_memreq", {31'b0, mif.memReq}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_outs", {31'b0, |{memDataOut, aluOutOut, setValOut, nextPcOut, regWrtOut,
                                     regWrtSrcOut, writeRegOut, haltOut, errOut, validOut}}, 32'd0);
        set_in(mk_in(16'h0033, 16'h0000, 16'h0044, 16'h0012, 1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 1'b0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b1;
        do_instr("post_rst",
                 mk_in(16'h0033, 16'h0000, 16'h0044, 16'h0012, 1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 1'b0, 1'b0),
                 0, 16'h0000, 0, 0,
                 mk_exp(16'h0000, 16'h0033, 16'h0044, 16'h0012, 1'b1, 3'd4, 3'd2, 1'b0, 1'b0));

        @(negedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the execute pipeline-register outputs: ALU result/address, store data, control bits and setVal.
- Drives a req/ack data-memory port with a variable-latency wait FSM and a timeout, and stalls upstream while an access is outstanding.
- Registers the result into the MEM/WB pipeline register feeding writeback.

Parameters:
- TIMEOUT_CYCLES, 16: cycles memReq may stay high without memAck before the access is aborted with an error; range 2..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  stage clock.
- rst  in  1  asynchronous, active-low reset.
- aluOut  in  16  ALU result; also the memory address.
- reg2Data  in  16  store data.
- setVal  in  16  SLT/SEQ-style set value, passed through.
- nextPc  in  16  PC+2, passed through for link writes.
- memEn  in  1  instruction accesses memory.
- memWrt  in  1  access is a store (valid only with memEn).
- regWrt  in  1  instruction writes the register file.
- regWrtSrc  in  3  writeback source select, passed through.
- writeReg  in  3  destination register, passed through.
- halt  in  1  halt marker, passed through.
- errIn  in  1  upstream error, passed through.
- memReq  out  1  memory request.
- memWr  out  1  request is a write.
- memAddr  out  16  request address.
- memWrData  out  16  write data.
- memAck  in  1  request complete; read data valid this cycle.
- memRdData  in  16  read data.
- stall  out  1  hold upstream stages; inputs must stay stable while high.
- memDataOut  out  16  registered load data.
- aluOutOut  out  16  registered aluOut.
- setValOut  out  16  registered setVal.
- nextPcOut  out  16  registered nextPc.
- regWrtOut  out  1  registered regWrt, gated (see Behaviour).
- regWrtSrcOut  out  3  registered regWrtSrc.
- writeRegOut  out  3  registered writeReg.
- haltOut  out  1  registered halt, gated.
- errOut  out  1  registered error.
- validOut  out  1  MEM/WB register holds a real instruction.

Behaviour:

Reset:
- rst=0 asynchronously forces FSM to IDLE and the wait counter to 0.
- Every registered output resets to 0.
- memReq and stall are 0 during reset.

FSM states are IDLE and WAIT.

IDLE:
- memReq = memEn (combinational).
- memWr = memWrt; memAddr = aluOut; memWrData = reg2Data.
- memEn=0: no request; instruction latches into MEM/WB at the next edge (1-cycle latency); validOut=1.
- memEn=1 and memAck=1 in the same cycle (zero-wait): stall=0; result latches next edge; memDataOut = memRdData for loads, 0 for stores.
- memEn=1 and memAck=0: stall=1; go to WAIT; counter := 1.

WAIT:
- memReq=1; address, data and write-enable are driven from the (held) inputs.
- memAck=1: stall=0; result latches; next state IDLE; counter := 0.
- memAck=0 and counter < TIMEOUT_CYCLES-1: stall=1; counter++.
- memAck=0 and counter = TIMEOUT_CYCLES-1: abort. This cycle: memReq=0, stall=0. Next edge: errOut=1, regWrtOut=0, validOut=1, haltOut=halt, memDataOut=0; state returns to IDLE.

Bubbles:
- On every edge where stall=1, MEM/WB loads a bubble: validOut=0, regWrtOut=0, haltOut=0, errOut=0. Data fields hold their previous values.

Pass-through and error rules:
- errOut = errIn OR abort OR alignment fault (see Optional Feature).
- Any error forces regWrtOut=0 for that instruction.
- memAck while memReq=0 is ignored.
- memWrt with memEn=0 causes no request.

Reset mid-access:
- memReq drops immediately; no retry is issued after reset release.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined: when memEn=1 and aluOut[0]=1, no request is issued and stall=0. Next edge: errOut=1, regWrtOut=0, validOut=1, memDataOut=0.
- Undefined: no alignment check; odd addresses go to memory unchanged.

Test Plan:
- Reset: rst=0 mid-WAIT with memReq=1 -> memReq=0, stall=0 immediately; all outputs 0; after release, memEn=0 instruction gives validOut=1 one cycle later.
- Zero-wait load: aluOut=0x0040, memEn=1, memWrt=0, memAck=1 same cycle, memRdData=0xBEEF -> stall never asserts; next cycle memDataOut=0xBEEF, validOut=1, regWrtOut=regWrt.
- 3-cycle store: aluOut=0x0100, reg2Data=0x1234, memWrt=1, memAck on 3rd request cycle -> memReq high 3 cycles with memAddr=0x0100, memWrData=0x1234, memWr=1; stall high 2 cycles; exactly two bubbles (validOut=0, regWrtOut=0), then validOut=1.
- Timeout: TIMEOUT_CYCLES=4, memEn=1, memAck never -> memReq high 3 cycles and 0 on the 4th (abort) cycle; stall high 3 cycles then 0; errOut=1, regWrtOut=0 after the 4th edge; FSM back in IDLE.
- Pass-through: non-memory instruction with setVal=0x0001, nextPc=0x0022, writeReg=5, regWrtSrc=2, halt=1 -> all appear on outputs one cycle later; memReq stays 0.
- MEM_ALIGN_CHK_EN defined: memEn=1, aluOut=0x0101 -> memReq=0; next cycle errOut=1, regWrtOut=0. Undefined: memReq=1 with memAddr=0x0101.
